// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multi-cycle MIPS main controller and its datapath.
// The datapath (master) supplies opcode and memory ready; the controller (slave) drives the controls.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] pc_source;
  logic [1:0] alu_op;
  logic [1:0] alu_src_b;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    output op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, reg_dst, alu_src_a, pc_source, alu_op,
           alu_src_b, illegal_op, state
  );

  modport slave (
    input  op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, reg_dst, alu_src_a, pc_source, alu_op,
           alu_src_b, illegal_op, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/write-back.
// state    | meaning
// FETCH    | read instruction, PC+4; waits on mem_ready
// DECODE   | register read, branch target into ALUOut
// MEMADDR  | compute lw/sw address
// MEMREAD  | data read; waits on mem_ready
// MEMWB    | load result to rt
// MEMWRITE | data write; waits on mem_ready
// EXECUTE  | R-type ALU operation
// RCOMP    | R-type result to rd
// BRANCH   | beq compare, conditional PC update
// JUMP     | PC <= jump target
// ADDIEX   | addi ALU operation
// ADDIWB   | addi result to rt
module mc_ctrl_fsm (
  input  logic           clk_i,
  input  logic           reset_i,
  mc_ctrl_fsm_if.slave   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RCOMP    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       mem_to_reg_c, ir_write_c, reg_write_c, reg_dst_c, alu_src_a_c;
  logic [1:0] pc_source_c, alu_op_c, alu_src_b_c;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d         = S_FETCH;
    illegal_d       = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    mem_to_reg_c    = 1'b0;
    ir_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    reg_dst_c       = 1'b0;
    alu_src_a_c     = 1'b0;
    pc_source_c     = 2'b00;
    alu_op_c        = 2'b00;
    alu_src_b_c     = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
        state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        alu_op_c    = 2'b00;
        case (bus.op)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        state_d    = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        state_d     = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b00;
        alu_op_c    = 2'b10;
        state_d     = S_RCOMP;
      end
      S_RCOMP: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c  = 1'b1;
        pc_source_c = 2'b10;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = 2'b00;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks the outputs in the same cycle so an aborted instruction never writes.
  assign bus.pc_write      = pc_write_c      & ~reset_i;
  assign bus.pc_write_cond = pc_write_cond_c & ~reset_i;
  assign bus.i_or_d        = i_or_d_c        & ~reset_i;
  assign bus.mem_read      = mem_read_c      & ~reset_i;
  assign bus.mem_write     = mem_write_c     & ~reset_i;
  assign bus.mem_to_reg    = mem_to_reg_c    & ~reset_i;
  assign bus.ir_write      = ir_write_c      & ~reset_i;
  assign bus.reg_write     = reg_write_c     & ~reset_i;
  assign bus.reg_dst       = reg_dst_c       & ~reset_i;
  assign bus.alu_src_a     = alu_src_a_c     & ~reset_i;
  assign bus.pc_source     = reset_i ? 2'b00 : pc_source_c;
  assign bus.alu_op        = reset_i ? 2'b00 : alu_op_c;
  assign bus.alu_src_b     = reset_i ? 2'b00 : alu_src_b_c;
  assign bus.illegal_op    = illegal_q & ~reset_i;
  assign bus.state         = reset_i ? 4'd0 : state_q;

endmodule
